// File: rtl/div8191_arbiter.sv
// Multi-requester divide-by-8191 unit: one shared datapath behind a 2-stage valid/ready pipeline.
// Optional feature: define DIV8191_ARB_RR_EN for round-robin arbitration (default is fixed priority).
module div8191_arbiter #(
  parameter int ID_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [(2**ID_W)-1:0]       req_valid,
  input  logic [32*(2**ID_W)-1:0]    req_x,
  output logic [(2**ID_W)-1:0]       req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [19:0]                res_q,
  output logic [12:0]                res_r,
  output logic [ID_W-1:0]            res_id,
  output logic                       busy,
  output logic [15:0]                done_cnt
);

  localparam int NREQ = 2**ID_W;

  // x/8191 = x/2^13 * (1 + 2^-13 + ...); the two-term estimate undershoots by at most 2, fixed up below.
  function automatic logic [32:0] div8191(input logic [31:0] x);
    logic [19:0] q;
    logic [32:0] rem;
    logic        c;
    q   = 20'(x >> 13) + 20'(x >> 26);
    rem = {1'b0, x} - ({q, 13'd0} - {13'd0, q});
    for (int i = 0; i < 2; i++) begin
      c   = (rem >= 33'd8191);
      rem = c ? (rem - 33'd8191) : rem;
      q   = q + {19'd0, c};
    end
    return {q, rem[12:0]};
  endfunction

  logic              r_s1_v;
  logic [31:0]       r_s1_x;
  logic [ID_W-1:0]   r_s1_id;
  logic              r_s2_v;
  logic [19:0]       r_q;
  logic [12:0]       r_r;
  logic [ID_W-1:0]   r_id;
  logic [15:0]       r_done_cnt;

  logic              w_s2_load;
  logic              w_s1_accept;
  logic              w_gnt_any;
  logic [ID_W-1:0]   w_gnt_id;
  logic [ID_W-1:0]   w_start;
  logic [31:0]       w_sel_x;
  logic              w_hs;
  logic [32:0]       w_div;

`ifdef DIV8191_ARB_RR_EN
  logic [ID_W-1:0]   r_ptr;

  // Round-robin pointer holds the index after the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_gnt_id + ID_W'(1);
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  assign w_s2_load   = r_s1_v && (!r_s2_v || res_ready);
  assign w_s1_accept = !r_s1_v || w_s2_load;

  // Grant search from w_start, wrapping over all requesters.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    logic            v_hit;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    v_idx     = '0;
    v_hit     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx     = w_start + ID_W'(i);
      v_hit     = req_valid[v_idx] && !w_gnt_any;
      w_gnt_id  = v_hit ? v_idx : w_gnt_id;
      w_gnt_any = w_gnt_any | v_hit;
    end
  end

  // Dividend mux for the granted requester.
  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_x = (w_gnt_id == ID_W'(i)) ? req_x[32*i +: 32] : w_sel_x;
    end
  end

  assign req_ready = (!rst && w_s1_accept && w_gnt_any)
                     ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
  assign w_hs      = |(req_valid & req_ready);
  assign w_div     = div8191(r_s1_x);

  // Stage 1: accepted dividend and requester id.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_s1_x  <= 32'd0;
      r_s1_id <= '0;
    end else if (w_s1_accept) begin
      r_s1_v  <= w_hs;
      r_s1_x  <= w_sel_x;
      r_s1_id <= w_gnt_id;
    end
  end

  // Stage 2: registered result, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_q    <= 20'd0;
      r_r    <= 13'd0;
      r_id   <= '0;
    end else if (w_s2_load) begin
      r_s2_v <= 1'b1;
      r_q    <= w_div[32:13];
      r_r    <= w_div[12:0];
      r_id   <= r_s1_id;
    end else if (res_ready) begin
      r_s2_v <= 1'b0;
    end
  end

  // Delivered-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_cnt <= 16'd0;
    end else if (r_s2_v && res_ready) begin
      r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

  assign res_valid = r_s2_v;
  assign res_q     = r_q;
  assign res_r     = r_r;
  assign res_id    = r_id;
  assign busy      = r_s1_v | r_s2_v;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_div8191_arbiter.sv
// Scoreboard bench for div8191_arbiter: stimulus pushes expected results, a monitor pops on delivery.
module tb_div8191_arbiter;

  localparam int ID_W = 2;
  localparam int NREQ = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [127:0]  req_x;
  logic [3:0]    req_ready;
  logic          res_valid;
  logic          res_ready;
  logic [19:0]   res_q;
  logic [12:0]   res_r;
  logic [1:0]    res_id;
  logic          busy;
  logic [15:0]   done_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_done = 0;
  logic [34:0]   sb[$];

  div8191_arbiter #(.ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_r(res_r),
    .res_id(res_id), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [34:0] mk(input int id, input logic [31:0] x);
    logic [31:0] q;
    logic [31:0] r;
    q = x / 32'd8191;
    r = x % 32'd8191;
    return {2'(id), q[19:0], r[12:0]};
  endfunction

  // Monitor: every delivered result must match the head of the scoreboard.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d q %0d r %0d, expected no result", res_id, res_q, res_r);
        end else begin
          e = sb.pop_front();
          check("res_id", 64'(res_id), 64'(e[34:33]));
          check("res_q", 64'(res_q), 64'(e[32:13]));
          check("res_r", 64'(res_r), 64'(e[12:0]));
          check("done_cnt_running", 64'(done_cnt), 64'(exp_done & 32'hFFFF));
          exp_done++;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_done = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_vec(input int id, input logic [31:0] x, input logic [19:0] q, input logic [12:0] r);
    logic acc;
    acc = 1'b0;
    req_x[id*32 +: 32] = x;
    req_valid = 4'b0001 << id;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        acc = 1'b1;
        sb.push_back({2'(id), q, r});
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic stream(input int n, input int id, input logic [31:0] base);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    req_valid = 4'b0001 << id;
    while (k < n && cyc < n + 50) begin
      req_x[id*32 +: 32] = base + 32'(k);
      @(negedge clk);
      if (req_ready[id]) begin
        sb.push_back(mk(id, base + 32'(k)));
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 4'b0000;
    check("stream_count", 64'(k), 64'(n));
    check("stream_cycles", 64'(cyc), 64'(n));
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] x_tab[6] = '{32'hFFFFFFFF, 32'd8191, 32'd8190, 32'd0, 32'd16383, 32'h80000000};
  logic [19:0] q_tab[6] = '{20'd524352, 20'd1, 20'd0, 20'd0, 20'd2, 20'd262176};
  logic [12:0] r_tab[6] = '{13'd63, 13'd0, 13'd8190, 13'd0, 13'd1, 13'd32};

  initial begin
    int acc;
    int g;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_x     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    check("rst_res_q", 64'(res_q), 64'd0);
    check("rst_res_r", 64'(res_r), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);

    // Arithmetic example and two-cycle latency, accepted in the first cycle after reset.
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0100;
    req_x[95:64] = 32'd124134134;
    @(negedge clk);
    check("first_cycle_ready", 64'(req_ready), 64'd4);
    if (req_ready[2]) sb.push_back({2'd2, 20'd15154, 13'd7720});
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("latency_c1_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("latency_c2_valid", 64'(res_valid), 64'd1);
    @(negedge clk);
    check("done_cnt_one", 64'(done_cnt), 64'd1);
    @(posedge clk); #1;

    // Boundary vectors spread over all requesters.
    for (int i = 0; i < 6; i++) send_vec(i % NREQ, x_tab[i], q_tab[i], r_tab[i]);
    drain();

    // Arbitration with all requesters valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) req_x[i*32 +: 32] = 32'd8191 * 32'(i + 1) + 32'(i);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef DIV8191_ARB_RR_EN
      g = k % NREQ;
`else
      g = 0;
`endif
      check("grant", 64'(req_ready), 64'(4'b0001 << g));
      if (req_ready[g]) sb.push_back({2'(g), 20'(g + 1), 13'(g)});
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    drain();

    // Backpressure: two accepted, outputs frozen, then release.
    res_ready = 1'b0;
    req_valid = 4'b0010;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      req_x[63:32] = 32'd8191000 + 32'(acc);
      @(negedge clk);
      if (req_ready[1]) begin
        sb.push_back({2'd1, 20'd1000, 13'(acc)});
        acc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(acc), 64'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_q_stable", 64'(res_q), 64'd1000);
      check("bp_r_stable", 64'(res_r), 64'd0);
      check("bp_id_stable", 64'(res_id), 64'd1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    for (int k = 0; k < 20 && acc < 6; k++) begin
      req_x[63:32] = 32'd8191000 + 32'(acc);
      @(negedge clk);
      if (req_ready[1]) begin
        sb.push_back({2'd1, 20'd1000, 13'(acc)});
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    check("bp_resumed", 64'(acc), 64'd6);
    drain();
    @(negedge clk);
    check("bp_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Reset with two entries in flight: nothing stale may emerge.
    res_ready = 1'b0;
    req_valid = 4'b1000;
    req_x[127:96] = 32'd5;
    acc = 0;
    for (int k = 0; k < 10 && acc < 2; k++) begin
      @(negedge clk);
      if (req_ready[3]) begin
        sb.push_back({2'd3, 20'd0, 13'd5});
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    check("mid_inflight", 64'(acc), 64'd2);
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_done", 64'(done_cnt), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_vec(3, 32'd100000, 20'd12, 13'd1708);
    drain();
    @(negedge clk);
    check("mid_done_after", 64'(done_cnt), 64'd1);
    @(posedge clk); #1;

    // Counter wrap after 65536 deliveries, streaming at full rate.
    do_reset();
    stream(65536, 0, 32'd0);
    drain();
    @(negedge clk);
    check("done_cnt_wrap", 64'(done_cnt), 64'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
